// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
// digit_t uses the default digit width; modules size their own buses from DIGIT_W.
package dsa_pkg;

   localparam int DIGIT_W_DFLT = 4;

   typedef logic [DIGIT_W_DFLT-1:0] digit_t;

   // Signed overflow from operand/result sign bits: like-signed operands, differently-signed result.
   function automatic logic ovf_f(input logic msb_a, input logic msb_b, input logic msb_s);
      return (msb_a ~^ msb_b) & (msb_a ^ msb_s);
   endfunction

endpackage

// File: rtl/dsa_digit_add.sv
// DIGIT_W-bit ripple of full adders built from logic ops only.
// Latency: combinational. Backpressure: none (pure datapath).
// Also reports the carry into the MSB bit for signed-overflow detection.
module dsa_digit_add
   import dsa_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout,
   output logic               c_msb
);

   // The chain is a local variable so each bit's carry feeds the next without a looped vector net.
   always_comb begin
      logic c;
      c     = cin;
      c_msb = cin;
      sum   = '0;
      for (int i = 0; i < DIGIT_W; i++) begin
         c_msb  = c;
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder, LSB digit first; carry held across digits, cleared per word.
// Latency: one cycle (registered output). Backpressure: in_ready = !out_valid | out_ready; outputs hold while stalled.
// Optional subtract mode (in_sub port, per-word sampled) enabled by `define DSA_SUB_EN.
module digit_serial_adder
   import dsa_pkg::*;
#(
   parameter int DIGIT_W     = 4,
   parameter int WORD_DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIGIT_W-1:0] in_a,
   input  logic [DIGIT_W-1:0] in_b,
`ifdef DSA_SUB_EN
   input  logic               in_sub,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIGIT_W-1:0] out_sum,
   output logic               out_last,
   output logic               out_carry,
   output logic               out_ovf
);

   localparam int               CNT_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_DIGITS - 1);

   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               accept;
   logic               first_dig;
   logic               last_dig;
   logic               sub_now;
   logic               cin;
   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W-1:0] sum_d;
   logic               cout_d;
   logic               c_msb_d;

   assign in_ready  = !out_valid | out_ready;
   assign accept    = in_valid & in_ready;
   assign first_dig = (cnt_q == '0);
   assign last_dig  = (cnt_q == CNT_LAST);

`ifdef DSA_SUB_EN
   logic word_sub_q;

   // Digit 0 takes in_sub live; the rest of the word uses the value captured with it.
   assign sub_now = first_dig ? in_sub : word_sub_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_sub_q <= 1'b0;
      end else if (accept && first_dig) begin
         word_sub_q <= in_sub;
      end
   end
`else
   assign sub_now = 1'b0;
`endif

   // Subtraction is A + ~B + 1: invert B and inject the +1 as digit-0 carry-in.
   assign b_eff = in_b ^ {DIGIT_W{sub_now}};
   assign cin   = first_dig ? sub_now : carry_q;

   dsa_digit_add #(
      .DIGIT_W (DIGIT_W)
   ) u_digit_add (
      .a     (in_a),
      .b     (b_eff),
      .cin   (cin),
      .sum   (sum_d),
      .cout  (cout_d),
      .c_msb (c_msb_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_last  <= 1'b0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (accept) begin
         cnt_q     <= last_dig ? '0 : cnt_q + CNT_W'(1);
         carry_q   <= !last_dig & cout_d;
         out_valid <= 1'b1;
         out_sum   <= sum_d;
         out_last  <= last_dig;
         out_carry <= last_dig & cout_d;
         out_ovf   <= last_dig & (c_msb_d ^ cout_d);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder (DIGIT_W=4, WORD_DIGITS=4): directed vectors plus random words vs an integer model.
// Subtract scenarios are built only when DSA_SUB_EN is defined.
module tb_digit_serial_adder;

   localparam int DW = 4;
   localparam int WD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
`ifdef DSA_SUB_EN
   logic          in_sub;
   bit            toggle_sub;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_sum;
   logic          out_last;
   logic          out_carry;
   logic          out_ovf;

   always #5 clk = ~clk;

   digit_serial_adder #(
      .DIGIT_W     (DW),
      .WORD_DIGITS (WD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef DSA_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_carry (out_carry),
      .out_ovf   (out_ovf)
   );

   logic [15:0] wa[$];
   logic [15:0] wb[$];
   logic        ws[$];
   logic [6:0]  rx[$];
   logic [6:0]  ex[$];
   int          valid_pct;
   int          ready_pct;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic push_word(input logic [15:0] a, input logic [15:0] b, input logic s);
      wa.push_back(a);
      wb.push_back(b);
      ws.push_back(s);
   endtask

   task automatic clear_words();
      wa.delete();
      wb.delete();
      ws.delete();
   endtask

   // Word-level model: integer add/subtract, then split the result into LSB-first digits.
   function automatic void build_expected();
      ex.delete();
      for (int i = 0; i < wa.size(); i++) begin
         int          av;
         int          bv;
         int          sav;
         int          sbv;
         int          r;
         int          sr;
         logic        c;
         logic        o;
         logic [15:0] rw;
         av  = int'(wa[i]);
         bv  = int'(wb[i]);
         sav = $signed(wa[i]);
         sbv = $signed(wb[i]);
         if (ws[i]) begin
            r  = av - bv;
            sr = sav - sbv;
            c  = (av >= bv);
         end else begin
            r  = av + bv;
            sr = sav + sbv;
            c  = (r > 65535);
         end
         o  = (sr > 32767) || (sr < -32768);
         rw = r[15:0];
         for (int d = 0; d < WD; d++) begin
            logic l;
            l = (d == WD - 1);
            ex.push_back({rw[4*d +: 4], l, l & c, l & o});
         end
      end
   endfunction

   // Streams the queued words in and records every delivered digit as {sum,last,carry,ovf}.
   task automatic run_words(input int budget);
      int   w;
      int   d;
      int   cyc;
      int   total;
      logic acc;
      w     = 0;
      d     = 0;
      cyc   = 0;
      total = wa.size() * WD;
      rx.delete();
      while ((w < wa.size() || rx.size() < total) && cyc < budget) begin
         if (w < wa.size()) begin
            in_valid = ($urandom_range(0, 99) < valid_pct);
            in_a     = wa[w][4*d +: 4];
            in_b     = wb[w][4*d +: 4];
`ifdef DSA_SUB_EN
            in_sub   = (d == 0 || !toggle_sub) ? ws[w] : !ws[w];
`endif
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid && out_ready) rx.push_back({out_sum, out_last, out_carry, out_ovf});
         @(posedge clk);
         #1;
         if (acc) begin
            if (d == WD - 1) begin
               d = 0;
               w++;
            end else begin
               d++;
            end
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_sum !== 4'h0) begin n_bad++; $display("FAIL reset out_sum: got %h want 0", out_sum); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
      n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL reset out_carry: got %b want 0", out_carry); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset out_ovf: got %b want 0", out_ovf); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_add_vectors();
      clear_words();
      push_word(16'h1234, 16'h0F0F, 1'b0);
      push_word(16'hFFFF, 16'h0001, 1'b0);
      push_word(16'h0000, 16'h0000, 1'b0);
      push_word(16'h7FFF, 16'h0001, 1'b0);
      push_word(16'h8000, 16'h8000, 1'b0);
      valid_pct = 100;
      ready_pct = 100;
      run_words(200);
      build_expected();
      n_cmp++; if (rx.size() !== ex.size()) begin n_bad++; $display("FAIL vectors count: got %0d digits want %0d", rx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
         n_cmp++;
         if (rx[i] !== ex[i]) begin n_bad++; $display("FAIL vectors digit %0d: got %h want %h ({sum,last,carry,ovf})", i, rx[i], ex[i]); end
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 4'h4; in_b = 4'hF;
      @(posedge clk); #1;
      n_cmp++; if (out_sum !== 4'h3 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall d0: got v=%b sum=%h want v=1 sum=3", out_valid, out_sum); end
      in_a = 4'h3; in_b = 4'h0;
      @(posedge clk); #1;
      n_cmp++; if (out_sum !== 4'h4) begin n_bad++; $display("FAIL stall d1: got sum=%h want 4", out_sum); end
      out_ready = 1'b0;
      in_a = 4'h2; in_b = 4'hF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_sum !== 4'h4 || out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall hold %0d: got sum=%h v=%b last=%b in_ready=%b want sum=4 v=1 last=0 in_ready=0", k, out_sum, out_valid, out_last, in_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (out_sum !== 4'h1 || out_last !== 1'b0) begin n_bad++; $display("FAIL stall d2: got sum=%h last=%b want sum=1 last=0", out_sum, out_last); end
      in_a = 4'h1; in_b = 4'h0;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_sum, out_last, out_carry, out_ovf} !== 7'b0010_1_0_0) begin
         n_bad++;
         $display("FAIL stall d3: got sum=%h last=%b c=%b ovf=%b want sum=2 last=1 c=0 ovf=0", out_sum, out_last, out_carry, out_ovf);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall drain: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_midword();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a = 4'h4; in_b = 4'hF;
      @(posedge clk); #1;
      in_a = 4'h3; in_b = 4'h0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_sum, out_last, out_carry, out_ovf} !== 8'h00) begin
         n_bad++;
         $display("FAIL midreset outputs: got v=%b sum=%h last=%b c=%b ovf=%b want all 0", out_valid, out_sum, out_last, out_carry, out_ovf);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      clear_words();
      push_word(16'h0001, 16'h0001, 1'b0);
      valid_pct = 100;
      ready_pct = 100;
      run_words(100);
      build_expected();
      n_cmp++; if (rx.size() !== ex.size()) begin n_bad++; $display("FAIL midreset count: got %0d digits want %0d", rx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
         n_cmp++;
         if (rx[i] !== ex[i]) begin n_bad++; $display("FAIL midreset digit %0d: got %h want %h ({sum,last,carry,ovf})", i, rx[i], ex[i]); end
      end
   endtask

   task automatic test_random();
      clear_words();
      for (int i = 0; i < 40; i++) push_word(16'($urandom), 16'($urandom), 1'b0);
      valid_pct = 70;
      ready_pct = 60;
      run_words(3000);
      build_expected();
      n_cmp++; if (rx.size() !== ex.size()) begin n_bad++; $display("FAIL random count: got %0d digits want %0d", rx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
         n_cmp++;
         if (rx[i] !== ex[i]) begin n_bad++; $display("FAIL random digit %0d: got %h want %h ({sum,last,carry,ovf})", i, rx[i], ex[i]); end
      end
   endtask

`ifdef DSA_SUB_EN
   task automatic test_sub();
      clear_words();
      push_word(16'h0005, 16'h0007, 1'b1);
      push_word(16'h8000, 16'h0001, 1'b1);
      push_word(16'h1234, 16'h0F0F, 1'b0);
      for (int i = 0; i < 30; i++) push_word(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      toggle_sub = 1'b1;
      valid_pct  = 80;
      ready_pct  = 70;
      run_words(3000);
      toggle_sub = 1'b0;
      build_expected();
      n_cmp++; if (rx.size() !== ex.size()) begin n_bad++; $display("FAIL sub count: got %0d digits want %0d", rx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
         n_cmp++;
         if (rx[i] !== ex[i]) begin n_bad++; $display("FAIL sub digit %0d: got %h want %h ({sum,last,carry,ovf})", i, rx[i], ex[i]); end
      end
   endtask
`endif

   initial begin
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
`ifdef DSA_SUB_EN
      in_sub     = 1'b0;
      toggle_sub = 1'b0;
`endif
      valid_pct = 100;
      ready_pct = 100;
      test_reset();
      test_add_vectors();
      test_stall();
      test_reset_midword();
      test_random();
`ifdef DSA_SUB_EN
      test_sub();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
